// File: rtl/enigma_pkg.sv
// enigma_pkg: shared definitions for the enigma stream controller.
//   - state_t   : controller FSM state encoding
//   - ASCII_*   : letter range bounds used for folding and core routing
//   - fold_case : maps 'a'..'z' to 'A'..'Z', leaves every other byte untouched
//   - is_upper  : true for 'A'..'Z'
package enigma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_Z     = 8'h5A;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_LZ    = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;
  localparam logic [7:0] ERR_CHAR    = 8'h3F;

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    logic [7:0] r;
    if ((c >= ASCII_LA) && (c <= ASCII_LZ)) begin
      r = c - CASE_OFFSET;
    end else begin
      r = c;
    end
    return r;
  endfunction

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/enigma_sync_fifo.sv
// enigma_sync_fifo: single-clock circular FIFO, DEPTH must be a power of two.
//   clk, reset_n   : clock, asynchronous active-low reset
//   push, din      : write request and data (ignored when full)
//   pop, dout      : read request (ignored when empty); dout shows the head entry
//   full, empty    : occupancy flags
//   count          : current occupancy, 0..DEPTH
module enigma_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= CW'(0);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/enigma_stream_ctrl.sv
// enigma_stream_ctrl: feeds a byte stream to the enigma core one letter at a
// time and returns results in the original order.
//   clk, reset_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     : upstream byte stream into an input FIFO
//   core_valid/core_din           : single-cycle issue pulse and folded letter
//   core_done/core_dout           : core completion pulse and result
//   out_valid/out_ready/out_data  : result stream (non-letters pass unchanged)
//   busy                          : FSM not idle or FIFO non-empty
//   fifo_count                    : input FIFO occupancy
//   timeout_err                   : sticky watchdog flag (ENIGMA_TIMEOUT_EN only)
// Optional build macro: ENIGMA_TIMEOUT_EN adds a WAIT-state watchdog that
// substitutes '?' for a result the core never delivers.
module enigma_stream_ctrl
  import enigma_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  output logic                          core_valid,
  output logic [7:0]                    core_din,
  input  logic                          core_done,
  input  logic [7:0]                    core_dout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef ENIGMA_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  // Reject illegal configurations at elaboration time.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
    $error("enigma_stream_ctrl: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  state_t     state;
  state_t     next_state;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] head;
  logic [7:0] head_folded;
  logic       head_is_letter;
  logic       timeout_hit;

  assign in_ready       = !fifo_full;
  assign fifo_push      = in_valid && in_ready;
  assign head_folded    = fold_case(head);
  assign head_is_letter = is_upper(head_folded);

  enigma_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (in_data),
    .pop     (fifo_pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef ENIGMA_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_cnt;

  // A done in the final watchdog cycle still wins over the timeout.
  assign timeout_hit = (state == ST_WAIT) && !core_done &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter (WAIT is only entered from ISSUE) and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt      <= WD_W'(0);
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_ISSUE) begin
        wd_cnt <= WD_W'(0);
      end else if (state == ST_WAIT) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          next_state = head_is_letter ? ST_ISSUE : ST_OUT;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        if (core_done || timeout_hit) begin
          next_state = ST_OUT;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_OUT;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the registered state.
  always_comb begin
    fifo_pop   = 1'b0;
    core_valid = 1'b0;
    out_valid  = 1'b0;
    busy       = !fifo_empty;
    case (state)
      ST_IDLE:  fifo_pop   = !fifo_empty;
      ST_ISSUE: begin core_valid = 1'b1; busy = 1'b1; end
      ST_WAIT:  busy       = 1'b1;
      ST_OUT:   begin out_valid  = 1'b1; busy = 1'b1; end
      default:  busy       = 1'b1;
    endcase
  end

  // Datapath: core_din holds outside ISSUE; out_data holds while in OUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_din <= 8'h00;
      out_data <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (head_is_letter) begin
              core_din <= head_folded;
            end else begin
              out_data <= head;
            end
          end
        end
        ST_WAIT: begin
          if (core_done) begin
            out_data <= core_dout;
          end else if (timeout_hit) begin
            out_data <= ERR_CHAR;
          end
        end
        default: begin
          core_din <= core_din;
          out_data <= out_data;
        end
      endcase
    end
  end

endmodule

// File: doc/enigma_stream_ctrl.md
Name: enigma_stream_ctrl

Overview:
Upstream feeder and downstream collector for the enigma cipher core. It buffers an incoming byte stream in a small FIFO and issues one letter at a time to the core as a single-cycle valid pulse. It waits for the core's done pulse, captures the result, and returns it on a valid/ready output stream in the original order. Non-letter bytes bypass the core unchanged; lowercase letters are folded to uppercase before ciphering.

Parameters:
- FIFO_DEPTH, 8, input FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only when ENIGMA_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream byte valid.
- in_ready  output  1  FIFO can accept a byte.
- in_data  input  8  upstream ASCII byte.
- core_valid  output  1  one-cycle issue pulse to the core valid input.
- core_din  output  8  byte issued to the core.
- core_done  input  1  core completion pulse.
- core_dout  input  8  core result; sampled only while core_done=1.
- out_valid  output  1  result byte available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  8  result byte.
- busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: in_ready=1, core_valid=0, core_din=0, out_valid=0, out_data=0, busy=0, fifo_count=0.
- Reset is asynchronous. Asserting it mid-operation discards the FIFO contents and any in-flight byte. The FSM returns to IDLE. The core shares reset_n, so no stale done is expected.
- FIFO push:
  - A byte is pushed when in_valid and in_ready are both high.
  - in_ready = (count != FIFO_DEPTH), computed from the registered count.
  - When the FIFO is full, in_ready stays 0 even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves the count unchanged.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - If the FIFO is non-empty, pop the head byte c.
  - If c is in 0x61-0x7A, fold it by subtracting 0x20.
  - If the folded c is in 0x41-0x5A, register core_din=c and go to ISSUE.
  - Otherwise load out_data=c (original byte, unfolded) and go to OUT.
- ISSUE: core_valid=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - On core_done=1, capture out_data=core_dout and go to OUT.
  - A core_done seen in IDLE, ISSUE or OUT is ignored.
- OUT: out_valid=1 and out_data are held stable until out_ready=1. Then go to IDLE; out_valid falls the next cycle.
- Only one byte is in flight at a time, so output order equals input order.
- Minimum latency from a FIFO push to out_valid:
  - Letter: push (1) + IDLE pop (1) + ISSUE (1) + core latency + capture (1).
  - Bypass byte: push (1) + IDLE pop (1), so out_valid is high 2 cycles after the push edge.
- Throughput for a bypass byte with out_ready held high: one byte every 2 cycles (IDLE, OUT).
- core_din holds its last value outside ISSUE.

Optional Feature:
ENIGMA_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each cycle spent in WAIT.
  - If it reaches TIMEOUT_CYCLES without core_done, out_data=0x3F ('?') and the FSM goes to OUT.
  - An extra output port timeout_err (1 bit) becomes a sticky flag, set on timeout and cleared only by reset_n.
  - A late core_done arriving after the timeout is ignored.
- Undefined: no counter and no timeout_err port; WAIT waits indefinitely.

Decomposition:
- Package enigma_pkg holds:
  - the FSM state encoding;
  - ASCII constants: ASCII_A=0x41, ASCII_Z=0x5A, ASCII_LA=0x61, ASCII_LZ=0x7A, CASE_OFFSET=0x20, ERR_CHAR=0x3F.
- One sub-module, enigma_sync_fifo, is natural:
  - parameterised depth and width;
  - push/pop, full/empty and count;
  - circular read/write pointers that wrap at FIFO_DEPTH.

Test Plan:
- Reset then push 'A' (0x41), with a core model of fixed 14-cycle latency returning 0x42 -> exactly one core_valid pulse with core_din=0x41; out_data=0x42 with out_valid high; busy=0 after out_ready.
- Push 'h', ' ', 'i' (0x68, 0x20, 0x69), core model returns input+1 -> outputs in order 0x49, 0x20, 0x4A; core_valid pulses exactly twice, with core_din 0x48 then 0x49.
- Hold out_ready=0 and push 9 bytes with FIFO_DEPTH=8 -> in_ready falls when fifo_count=8; no byte lost or duplicated once out_ready is released; out_data is stable while stalled.
- Inject a spurious core_done with core_dout=0x55 while in IDLE -> no output is produced and the following byte's result is unaffected.
- Assert reset_n low during WAIT with 3 bytes queued -> all outputs return to reset values immediately; after release, a new byte 'Q' is processed normally.
- With ENIGMA_TIMEOUT_EN, TIMEOUT_CYCLES=64, and a core model that never sends done -> out_data=0x3F exactly 64 cycles after WAIT entry; timeout_err=1 and stays set; a late core_done is ignored.
